// File: rtl/alu_cmd_loader_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_loader_if
//   Bundles every non-clock, non-reset signal of the ALU command loader:
//   the byte-serial pad input, the command handshake towards the ALU, the
//   result return path from the ALU and the held result/status outputs.
//
//   master : the loader itself (drives the ALU command and the held outputs)
//   slave  : the surroundings (pads + ALU), driving bytes, ready and results
//
//   Signals
//     in_data[7:0]     command/operand byte from the pads
//     in_valid         one-cycle strobe qualifying in_data
//     alu_op[3:0]      opcode to ALU
//     alu_a[7:0]       operand A to ALU
//     alu_b[7:0]       operand B to ALU
//     alu_valid        command valid to ALU
//     alu_ready        ALU accepts command when alu_valid && alu_ready
//     alu_result[7:0]  ALU result
//     alu_flags[3:0]   ALU flags {C,Z,N,V}
//     alu_res_valid    one-cycle strobe qualifying result/flags
//     out_data[7:0]    held result
//     out_flags[3:0]   held flags
//     out_valid        out_data/out_flags hold a fresh result
//     busy             loader is in the middle of a frame or command
//     err              sticky error: bad opcode, timeout or overrun
// ---------------------------------------------------------------------------
interface alu_cmd_loader_if;

   logic [7:0] in_data;
   logic       in_valid;

   logic [3:0] alu_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic       alu_valid;
   logic       alu_ready;

   logic [7:0] alu_result;
   logic [3:0] alu_flags;
   logic       alu_res_valid;

   logic [7:0] out_data;
   logic [3:0] out_flags;
   logic       out_valid;
   logic       busy;
   logic       err;

   modport master (
      input  in_data,
      input  in_valid,
      output alu_op,
      output alu_a,
      output alu_b,
      output alu_valid,
      input  alu_ready,
      input  alu_result,
      input  alu_flags,
      input  alu_res_valid,
      output out_data,
      output out_flags,
      output out_valid,
      output busy,
      output err
   );

   modport slave (
      output in_data,
      output in_valid,
      input  alu_op,
      input  alu_a,
      input  alu_b,
      input  alu_valid,
      output alu_ready,
      output alu_result,
      output alu_flags,
      output alu_res_valid,
      input  out_data,
      input  out_flags,
      input  out_valid,
      input  busy,
      input  err
   );

endinterface

// File: rtl/alu_cmd_loader.sv
// ---------------------------------------------------------------------------
// alu_cmd_loader
//   Byte-serial command front end for the ALU core. A frame is an opcode
//   byte ([7:4] = op, [3:0] = 0) followed by operand A and, for binary
//   opcodes, operand B. Once the frame is complete the command is offered
//   to the ALU over a valid/ready handshake; the returned result and flags
//   are captured and held on the output pins until the next result.
//
//   Parameters
//     TIMEOUT_CYC  idle cycles allowed between bytes of one frame
//     UNARY_BASE   opcodes >= this take operand A only (B forced to 0)
//
//   Ports
//     clk   system clock, rising edge
//     rst   asynchronous reset, active high
//     bus   alu_cmd_loader_if.master (pad bytes, ALU command/result, held
//           outputs, busy and sticky err)
// ---------------------------------------------------------------------------
module alu_cmd_loader #(
   parameter int         TIMEOUT_CYC = 1000,
   parameter logic [3:0] UNARY_BASE  = 4'hC
) (
   input logic              clk,
   input logic              rst,
   alu_cmd_loader_if.master bus
);

   localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_A,
      S_GET_B,
      S_ISSUE,
      S_WAIT_RES,
      S_HOLD
   } state_t;

   state_t            state;
   state_t            next_state;

   logic [3:0]        op_q;
   logic [7:0]        a_q;
   logic [7:0]        b_q;
   logic [7:0]        out_data_q;
   logic [3:0]        out_flags_q;
   logic              out_valid_q;
   logic              err_q;
   logic [CNT_W-1:0]  idle_cnt;

   logic              op_unary;
   logic              op_take;
   logic              op_bad;
   logic              a_take;
   logic              b_take;
   logic              res_take;
   logic              overrun;
   logic              timed_out;
   logic              collecting;

   assign op_unary   = (op_q >= UNARY_BASE);
   assign collecting = (state == S_GET_A) || (state == S_GET_B);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode plus one-cycle strobes for the datapath. IDLE and
   // HOLD treat incoming bytes identically; the only difference is that
   // HOLD still presents the previous result. A byte arriving in the same
   // cycle the timeout would fire wins, so a frame is never dropped while
   // its byte is on the pins.
   always_comb begin
      next_state = state;
      op_take    = 1'b0;
      op_bad     = 1'b0;
      a_take     = 1'b0;
      b_take     = 1'b0;
      res_take   = 1'b0;
      overrun    = 1'b0;
      timed_out  = 1'b0;

      case (state)
         S_IDLE, S_HOLD: begin
            if (bus.in_valid) begin
               if (bus.in_data[3:0] == 4'h0) begin
                  op_take    = 1'b1;
                  next_state = S_GET_A;
               end else begin
                  op_bad = 1'b1;
               end
            end
         end

         S_GET_A: begin
            if (bus.in_valid) begin
               a_take = 1'b1;
               if (op_unary) begin
                  next_state = S_ISSUE;
               end else begin
                  next_state = S_GET_B;
               end
            end else if (idle_cnt == CNT_LAST) begin
               timed_out  = 1'b1;
               next_state = S_IDLE;
            end
         end

         S_GET_B: begin
            if (bus.in_valid) begin
               b_take     = 1'b1;
               next_state = S_ISSUE;
            end else if (idle_cnt == CNT_LAST) begin
               timed_out  = 1'b1;
               next_state = S_IDLE;
            end
         end

         S_ISSUE: begin
            overrun = bus.in_valid;
            if (bus.alu_ready) begin
               next_state = S_WAIT_RES;
            end
         end

         S_WAIT_RES: begin
            overrun = bus.in_valid;
            if (bus.alu_res_valid) begin
               res_take   = 1'b1;
               next_state = S_HOLD;
            end
         end

         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Inter-byte idle counter. It only runs while a frame is being collected
   // and restarts on every byte, so leaving GET_A/GET_B always clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (collecting && !bus.in_valid) begin
         idle_cnt <= idle_cnt + CNT_W'(1);
      end else begin
         idle_cnt <= '0;
      end
   end

   // Command registers. They only load while a frame is being collected,
   // which keeps op/a/b stable for the whole time alu_valid is high. A
   // unary opcode clears B when A arrives so a stale operand never reaches
   // the ALU.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
      end else begin
         if (op_take) begin
            op_q <= bus.in_data[7:4];
         end
         if (a_take) begin
            a_q <= bus.in_data;
            if (op_unary) begin
               b_q <= '0;
            end
         end
         if (b_take) begin
            b_q <= bus.in_data;
         end
      end
   end

   // Result capture and status. out_data/out_flags are only overwritten by
   // a new result; out_valid drops as soon as a new frame starts so a stale
   // result is never mistaken for the answer to the new command. err is
   // sticky and only a legal opcode byte clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_flags_q <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (res_take) begin
            out_data_q  <= bus.alu_result;
            out_flags_q <= bus.alu_flags;
         end

         if (op_take) begin
            out_valid_q <= 1'b0;
         end else if (res_take) begin
            out_valid_q <= 1'b1;
         end

         if (op_take) begin
            err_q <= 1'b0;
         end else if (op_bad || overrun || timed_out) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.alu_op    = op_q;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_valid = (state == S_ISSUE);
   assign bus.out_data  = out_data_q;
   assign bus.out_flags = out_flags_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state != S_IDLE) && (state != S_HOLD);
   assign bus.err       = err_q;

endmodule
